// File: rtl/lisnoc_mp_simple_out_arb_pkg.sv
// Shared definitions for the message-passing output arbiter: flit type codes,
// arbiter state encoding and a compile-time log2 helper.
package lisnoc_mp_simple_out_arb_pkg;

    typedef enum logic [1:0] {
        FLIT_PAYLOAD = 2'b00,
        FLIT_HEADER  = 2'b01,
        FLIT_LAST    = 2'b10,
        FLIT_SINGLE  = 2'b11
    } flit_type_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int FLIT_TYPE_WIDTH = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lisnoc_arb_rr.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// searching upward and wrapping from ports-1 back to 0.
module lisnoc_arb_rr #(
    parameter int ports     = 2,
    parameter int sel_width = 1
) (
    input  logic [ports-1:0]     req,
    input  logic [sel_width-1:0] ptr,
    output logic [ports-1:0]     gnt,
    output logic [sel_width-1:0] idx,
    output logic                 any
);

    int cand_s;

    // priority search starting at the pointer position
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = 0;
        for (int i = 0; i < ports; i++) begin
            cand_s = (int'(ptr) + i) % ports;
            if (!any && req[cand_s]) begin
                any = 1'b1;
                idx = sel_width'(cand_s);
            end else begin
                any = any;
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/lisnoc_mp_simple_out_arb.sv
// Packet-atomic round-robin arbiter sharing one NoC output link between
// several message-passing sources, with a one-entry registered output.
module lisnoc_mp_simple_out_arb
    import lisnoc_mp_simple_out_arb_pkg::*;
#(
    parameter int noc_data_width = 32,
    parameter int noc_type_width = 2,
    parameter int ports          = 2,
    localparam int flit_width    = noc_data_width + noc_type_width,
    localparam int sel_width     = clog2(ports)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ports*flit_width-1:0] in_flit,
    input  logic [ports-1:0]            in_valid,
    output logic [ports-1:0]            in_ready,
    output logic [flit_width-1:0]       out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [sel_width-1:0]        out_owner
);

    arb_state_e             state_r;
    logic [sel_width-1:0]   ptr_r;
    logic [sel_width-1:0]   lock_r;
    logic [flit_width-1:0]  out_flit_r;
    logic                   out_valid_r;
    logic [sel_width-1:0]   out_owner_r;

    logic                   space_s;
    logic [ports-1:0]       gnt_s;
    logic [sel_width-1:0]   win_idx_s;
    logic                   win_any_s;
    logic [sel_width-1:0]   sel_s;
    logic [ports-1:0]       ready_s;
    logic                   xfer_s;
    logic [flit_width-1:0]  sel_flit_s;
    flit_type_e             sel_type_s;

    function automatic logic [sel_width-1:0] next_ptr(input logic [sel_width-1:0] cur);
        if (int'(cur) == ports - 1) begin
            return '0;
        end else begin
            return cur + sel_width'(1);
        end
    endfunction

    lisnoc_arb_rr #(
        .ports     (ports),
        .sel_width (sel_width)
    ) u_arb (
        .req (in_valid),
        .ptr (ptr_r),
        .gnt (gnt_s),
        .idx (win_idx_s),
        .any (win_any_s)
    );

    // the out register can accept a flit when empty or draining this cycle
    assign space_s = ~out_valid_r | out_ready;

    // source selection and ready generation; a locked packet blocks everyone else
    always_comb begin
        ready_s = '0;
        sel_s   = '0;
        if (state_r == ST_LOCKED) begin
            sel_s          = lock_r;
            ready_s[lock_r] = space_s;
        end else begin
            sel_s = win_idx_s;
            if (win_any_s) begin
                ready_s = gnt_s & {ports{space_s}};
            end else begin
                ready_s = '0;
            end
        end
        sel_flit_s = in_flit[sel_s*flit_width +: flit_width];
        sel_type_s = flit_type_e'(sel_flit_s[flit_width-1 -: FLIT_TYPE_WIDTH]);
        xfer_s     = |(ready_s & in_valid);
    end

    // out register, packet lock and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            lock_r      <= '0;
            out_flit_r  <= '0;
            out_valid_r <= 1'b0;
            out_owner_r <= '0;
        end else begin
            if (xfer_s) begin
                out_flit_r  <= sel_flit_s;
                out_valid_r <= 1'b1;
                out_owner_r <= sel_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        if (sel_type_s == FLIT_HEADER) begin
                            state_r <= ST_LOCKED;
                            lock_r  <= sel_s;
                        end else begin
                            // SINGLE, or a stray PAYLOAD/LAST forwarded without locking
                            ptr_r <= next_ptr(sel_s);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (xfer_s && (sel_type_s == FLIT_LAST)) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= next_ptr(lock_r);
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = ready_s;
    assign out_flit  = out_flit_r;
    assign out_valid = out_valid_r;
    assign out_owner = out_owner_r;

endmodule

// File: tb/tb_lisnoc_mp_simple_out_arb.sv
// Bench for the packet-atomic output arbiter (4 sources): directed vector table
// followed by randomized traffic checked against a behavioural model.
module tb_lisnoc_mp_simple_out_arb;

    localparam int P  = 4;
    localparam int FW = 34;
    localparam logic [1:0] TP = 2'b00;
    localparam logic [1:0] TH = 2'b01;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [1:0] TS = 2'b11;
    localparam logic [FW-1:0] Z = 34'h0;

    logic              clk = 1'b0;
    logic              rst_s;
    logic [P*FW-1:0]   in_flit;
    logic [P-1:0]      in_valid;
    logic [P-1:0]      in_ready;
    logic [FW-1:0]     out_flit;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_owner;

    int vectors = 0;
    int errors  = 0;

    lisnoc_mp_simple_out_arb #(
        .noc_data_width (32),
        .noc_type_width (2),
        .ports          (P)
    ) dut (
        .clk       (clk),
        .rst       (rst_s),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_owner (out_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              rst;
        logic [P-1:0]    v;
        logic [P*FW-1:0] f;
        bit              ordy;
        logic [P-1:0]    e_rdy;
        bit              e_ov;
        logic [FW-1:0]   e_of;
        logic [1:0]      e_oo;
    } vec_t;

    // Behavioural model: a lock owner (or none), a rotating start index and the
    // contents of the one-entry output buffer.
    bit            m_locked = 1'b0;
    int            m_lock   = 0;
    int            m_ptr    = 0;
    bit            m_ov     = 1'b0;
    logic [FW-1:0] m_of     = '0;
    int            m_oo     = 0;
    int            m_sel    = -1;
    logic [P-1:0]  m_rdy    = '0;

    function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    function automatic vec_t mkv(input bit rst, input logic [P-1:0] v,
                                 input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                                 input logic [FW-1:0] f2, input logic [FW-1:0] f3,
                                 input bit ordy, input logic [P-1:0] erdy,
                                 input bit eov, input logic [FW-1:0] eof, input logic [1:0] eoo);
        vec_t r;
        r.rst = rst; r.v = v; r.f = {f3, f2, f1, f0}; r.ordy = ordy;
        r.e_rdy = erdy; r.e_ov = eov; r.e_of = eof; r.e_oo = eoo;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_comb();
        bit space;
        space = !m_ov || out_ready;
        m_rdy = '0;
        m_sel = -1;
        if (m_locked) begin
            m_sel = m_lock;
        end else begin
            for (int k = 0; k < P; k++) begin
                if (in_valid[(m_ptr + k) % P]) begin
                    m_sel = (m_ptr + k) % P;
                    break;
                end
            end
        end
        if (m_sel >= 0 && space) m_rdy[m_sel] = 1'b1;
    endtask

    task automatic model_seq();
        logic [FW-1:0] f;
        logic [1:0]    t;
        if (!rst_s) begin
            m_locked = 1'b0; m_lock = 0; m_ptr = 0; m_ov = 1'b0; m_of = '0; m_oo = 0;
        end else if (m_sel >= 0 && m_rdy[m_sel] && in_valid[m_sel]) begin
            f = in_flit[m_sel*FW +: FW];
            t = f[FW-1 -: 2];
            m_ov = 1'b1; m_of = f; m_oo = m_sel;
            if (!m_locked) begin
                if (t == TH) begin
                    m_locked = 1'b1; m_lock = m_sel;
                end else begin
                    m_ptr = (m_sel + 1) % P;
                end
            end else if (t == TL) begin
                m_locked = 1'b0; m_ptr = (m_lock + 1) % P;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic step(input vec_t r, input bit use_model);
        logic [P-1:0]  er;
        bit            eov;
        logic [FW-1:0] eof;
        logic [1:0]    eoo;
        rst_s = r.rst; in_valid = r.v; in_flit = r.f; out_ready = r.ordy;
        #2;
        model_comb();
        er = use_model ? m_rdy : r.e_rdy;
        if (r.rst) chk("in_ready", 64'(in_ready), 64'(er));
        @(posedge clk);
        model_seq();
        #1;
        eov = use_model ? m_ov : r.e_ov;
        eof = use_model ? m_of : r.e_of;
        eoo = use_model ? 2'(m_oo) : r.e_oo;
        chk("out_valid", 64'(out_valid), 64'(eov));
        if (eov || !r.rst) begin
            chk("out_flit", 64'(out_flit), 64'(eof));
            chk("out_owner", 64'(out_owner), 64'(eoo));
        end
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst_s = 1'b0; in_valid = '0; in_flit = '0; out_ready = 1'b1;

        // reset, then release with nothing requesting
        tbl.push_back(mkv(0, 4'b0000, Z, Z, Z, Z, 1, 4'b0000, 0, Z, 2'd0));
        tbl.push_back(mkv(0, 4'b0000, Z, Z, Z, Z, 1, 4'b0000, 0, Z, 2'd0));
        tbl.push_back(mkv(1, 4'b0000, Z, Z, Z, Z, 1, 4'b0000, 0, Z, 2'd0));
        // port0 packet holds off port1's SINGLE until LAST is taken
        tbl.push_back(mkv(1, 4'b0011, fl(TH, 32'h10), fl(TS, 32'h20), Z, Z, 1, 4'b0001, 1, fl(TH, 32'h10), 2'd0));
        tbl.push_back(mkv(1, 4'b0011, fl(TP, 32'h11), fl(TS, 32'h20), Z, Z, 1, 4'b0001, 1, fl(TP, 32'h11), 2'd0));
        tbl.push_back(mkv(1, 4'b0011, fl(TL, 32'h12), fl(TS, 32'h20), Z, Z, 1, 4'b0001, 1, fl(TL, 32'h12), 2'd0));
        tbl.push_back(mkv(1, 4'b0010, Z, fl(TS, 32'h20), Z, Z, 1, 4'b0010, 1, fl(TS, 32'h20), 2'd1));
        // continuous SINGLEs alternate owners
        tbl.push_back(mkv(1, 4'b0011, fl(TS, 32'h30), fl(TS, 32'h31), Z, Z, 1, 4'b0001, 1, fl(TS, 32'h30), 2'd0));
        tbl.push_back(mkv(1, 4'b0011, fl(TS, 32'h30), fl(TS, 32'h31), Z, Z, 1, 4'b0010, 1, fl(TS, 32'h31), 2'd1));
        tbl.push_back(mkv(1, 4'b0011, fl(TS, 32'h32), fl(TS, 32'h33), Z, Z, 1, 4'b0001, 1, fl(TS, 32'h32), 2'd0));
        tbl.push_back(mkv(1, 4'b0011, fl(TS, 32'h32), fl(TS, 32'h33), Z, Z, 1, 4'b0010, 1, fl(TS, 32'h33), 2'd1));
        // back-pressure for five cycles in the middle of a packet
        tbl.push_back(mkv(1, 4'b0001, fl(TH, 32'h40), Z, Z, Z, 1, 4'b0001, 1, fl(TH, 32'h40), 2'd0));
        tbl.push_back(mkv(1, 4'b0001, fl(TP, 32'h41), Z, Z, Z, 1, 4'b0001, 1, fl(TP, 32'h41), 2'd0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mkv(1, 4'b0001, fl(TP, 32'h42), Z, Z, Z, 0, 4'b0000, 1, fl(TP, 32'h41), 2'd0));
        tbl.push_back(mkv(1, 4'b0001, fl(TP, 32'h42), Z, Z, Z, 1, 4'b0001, 1, fl(TP, 32'h42), 2'd0));
        tbl.push_back(mkv(1, 4'b0001, fl(TL, 32'h43), Z, Z, Z, 1, 4'b0001, 1, fl(TL, 32'h43), 2'd0));
        tbl.push_back(mkv(1, 4'b0000, Z, Z, Z, Z, 1, 4'b0000, 0, Z, 2'd0));
        // reset mid-packet returns the pointer to 0
        tbl.push_back(mkv(1, 4'b0010, Z, fl(TH, 32'h50), Z, Z, 1, 4'b0010, 1, fl(TH, 32'h50), 2'd1));
        tbl.push_back(mkv(0, 4'b0000, Z, Z, Z, Z, 1, 4'b0000, 0, Z, 2'd0));
        tbl.push_back(mkv(1, 4'b0101, fl(TS, 32'h60), Z, fl(TS, 32'h62), Z, 1, 4'b0001, 1, fl(TS, 32'h60), 2'd0));
        // stray PAYLOAD in IDLE is forwarded without locking
        tbl.push_back(mkv(1, 4'b0010, Z, fl(TP, 32'h33), Z, Z, 1, 4'b0010, 1, fl(TP, 32'h33), 2'd1));
        tbl.push_back(mkv(1, 4'b0001, fl(TS, 32'h70), Z, Z, Z, 1, 4'b0001, 1, fl(TS, 32'h70), 2'd0));
        tbl.push_back(mkv(1, 4'b0000, Z, Z, Z, Z, 1, 4'b0000, 0, Z, 2'd0));
        // pointer wraps from the top port back to port 0
        tbl.push_back(mkv(1, 4'b1000, Z, Z, Z, fl(TS, 32'h73), 1, 4'b1000, 1, fl(TS, 32'h73), 2'd3));
        tbl.push_back(mkv(1, 4'b1001, fl(TS, 32'h80), Z, Z, fl(TS, 32'h83), 1, 4'b0001, 1, fl(TS, 32'h80), 2'd0));
        tbl.push_back(mkv(1, 4'b0000, Z, Z, Z, Z, 1, 4'b0000, 0, Z, 2'd0));

        foreach (tbl[i]) step(tbl[i], 1'b0);

        for (int n = 0; n < 3000; n++) begin
            rv.rst  = ($urandom_range(0, 199) != 0);
            rv.v    = 4'($urandom);
            for (int p = 0; p < P; p++)
                rv.f[p*FW +: FW] = fl(2'($urandom), $urandom);
            rv.ordy = ($urandom_range(0, 3) != 0);
            rv.e_rdy = '0; rv.e_ov = 1'b0; rv.e_of = '0; rv.e_oo = '0;
            step(rv, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
